fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction prefetch unit that sits upstream of the IF/ID register and replaces the direct PC->instruction_mem path.
//  Issues in-order fetch requests to an instruction memory with variable latency (valid/ready request, valid-only response).
//  Buffers returned words with their PC+4 in a small FIFO and presents them to IF/ID through a valid/ready handshake.
//  A branch/jump redirect from ID flushes the queue and squashes in-flight responses.
// PARAMETERS
//  DEPTH     4   FIFO entries; power of 2, >=2
//  MAX_OUT   2   max in-flight memory requests; 1..DEPTH
//  RESET_PC  0   32-bit fetch address after reset
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous, active-low reset
//  redirect       in   1   branch/jump taken in ID (PCsrc!=0); 1-cycle pulse
//  redirect_pc    in   32  new fetch address (branch target or jump PC)
//  imem_req_valid out  1   request valid
//  imem_req_ready in   1   memory accepts request
//  imem_req_addr  out  32  request address (= fetch_pc)
//  imem_rsp_valid in   1   response word valid; responses return in request order
//  imem_rsp_data  in   32  response instruction word
//  inst_valid     out  1   FIFO head valid toward IF/ID
//  inst_ready     in   1   IF/ID accepts (IF_ID_write)
//  inst           out  32  head instruction
//  inst_pc_plus4  out  32  head PC+4
// BEHAVIOUR
//  State: fetch_pc, rsp_pc (32b each); FIFO of {pc_plus4,inst}; rd/wr pointers + count (0..DEPTH);
//   outstanding (0..MAX_OUT); discard (0..MAX_OUT).
//  Reset (rst low, async): fetch_pc=rsp_pc=RESET_PC; count=outstanding=discard=0; pointers 0.
//   Outputs during and after reset: inst_valid=0, inst=0, inst_pc_plus4=0, imem_req_addr=RESET_PC.
//  live = outstanding - discard.
//  imem_req_valid = !redirect && outstanding<MAX_OUT && (count+live)<DEPTH (credit rule: FIFO never overflows).
//  Request accept (req_valid&&req_ready): fetch_pc+=4 (mod 2^32, wraps); outstanding+1.
//  Response (rsp_valid): outstanding-1. If discard>0: word dropped, discard-1.
//   Else push {rsp_pc+4, rsp_data}; rsp_pc+=4.
//  inst_valid = count!=0 && !redirect; head fields driven straight from FIFO read entry (no bubble).
//  Pop on inst_valid&&inst_ready; push and pop in the same cycle leave count unchanged.
//  Latency: response in cycle N -> inst_valid in cycle N+1 (FIFO previously empty). Zero-latency bypass is forbidden.
//  Redirect (highest priority, same edge): fetch_pc=rsp_pc=redirect_pc; FIFO emptied (count=0, rd=wr);
//   no push and no pop this cycle; no request issued this cycle.
//   discard <= outstanding - rsp_valid (all in-flight words squashed, including those already marked).
//   A response arriving in the redirect cycle is treated as old and dropped.
//  First request to redirect_pc is issued the cycle after redirect if credit allows.
//  Back-to-back redirects: the second overrides; discard recomputed from the current outstanding count.
//  Stall (inst_ready=0): FIFO fills; requests stop once count+live==DEPTH; resume on the next pop.
//  rsp_valid with outstanding==0 is illegal; rsp_valid is ignored and an assertion fires.
//   Push when count==DEPTH also fires an assertion.
//  redirect_pc[1:0] is not checked; it is used as given.
// TESTING
//  1. Release reset, req_ready=1, rsp 1 cycle after accept, inst_ready=1.
//     -> addrs 0,4,8.. issued; inst_pc_plus4 4,8,12.. in order, one per cycle steady state.
//  2. inst_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 words queued, req_valid low.
//     inst_ready=1 -> the 4 words drain in order, then fetch resumes with no loss or duplication.
//  3. Two requests in flight (addrs 0x10,0x14), redirect to 0x100 -> both responses dropped.
//     Next inst_valid carries inst_pc_plus4=0x104.
//  4. Redirect in the same cycle as rsp_valid and a pop -> rsp dropped, head not consumed (inst_valid=0 that cycle).
//     count=0 next cycle.
//  5. fetch_pc=0xFFFFFFFC accepted -> next imem_req_addr=0x0.
//     That entry's inst_pc_plus4=0x0.
//  6. Assert rst mid-stream with FIFO 3/4 full and 2 in flight -> inst_valid=0 immediately.
//     After release, first req addr=RESET_PC and no stale word is delivered.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction prefetcher between instruction memory and IF/ID.
// Latency: a response word is visible at the FIFO head the cycle after it returns. There is no bypass.
// Backpressure: requests are credit-limited so that queued plus live in-flight words never exceed DEPTH.
//              A stall on inst_ready therefore halts fetch once the queue is full.
// Ports:
//   clk, rst (async, active-low)
//   redirect/redirect_pc                             : flush and restart fetch from a new PC
//   imem_req_valid/ready/addr                        : fetch request channel
//   imem_rsp_valid/data                              : in-order response channel (valid only)
//   inst_valid/ready, inst, inst_pc_plus4            : FIFO head toward IF/ID
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned MAX_OUT  = 2,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc_plus4
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned OW = $clog2(MAX_OUT + 1);
   localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;

   typedef struct packed {
      logic [31:0] pc_plus4;
      logic [31:0] inst;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [OW-1:0]   outstanding_q, outstanding_d;
   logic [OW-1:0]   discard_q, discard_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [31:0]     rsp_pc_q, rsp_pc_d;

   logic [OW-1:0]   live;
   logic [SW-1:0]   credit_used;
   logic            req_fire;
   logic            rsp_ok;
   logic            push;
   logic            pop;

   // Handshake and credit logic.
   always_comb begin
      // Squashed words still occupy a memory slot but never land in the FIFO,
      // so only the live ones consume FIFO credit.
      live           = outstanding_q - discard_q;
      credit_used    = SW'(count_q) + SW'(live);
      imem_req_valid = !redirect && (outstanding_q < OW'(MAX_OUT)) && (credit_used < SW'(DEPTH));
      imem_req_addr  = fetch_pc_q;
      req_fire       = imem_req_valid && imem_req_ready;
      // A response with nothing outstanding is illegal and is ignored.
      rsp_ok         = imem_rsp_valid && (outstanding_q != '0);
      // Responses in a redirect cycle belong to the old stream and are dropped.
      push           = rsp_ok && !redirect && (discard_q == '0);
      inst_valid     = (count_q != '0) && !redirect;
      pop            = inst_valid && inst_ready;
      inst           = mem_q[rd_ptr_q].inst;
      inst_pc_plus4  = mem_q[rd_ptr_q].pc_plus4;
   end

   // Next-state logic.
   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = '{pc_plus4: rsp_pc_q + 32'd4, inst: imem_rsp_data};
      end

      outstanding_d = outstanding_q + OW'(req_fire) - OW'(rsp_ok);

      if (redirect) begin
         fetch_pc_d = redirect_pc;
         rsp_pc_d   = redirect_pc;
         rd_ptr_d   = wr_ptr_q;
         wr_ptr_d   = wr_ptr_q;
         count_d    = '0;
         // Every word still in flight after this edge belongs to the old stream.
         discard_d  = outstanding_q - OW'(rsp_ok);
      end else begin
         fetch_pc_d = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
         rsp_pc_d   = push ? rsp_pc_q + 32'd4 : rsp_pc_q;
         rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
         wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
         count_d    = count_q + CW'(push) - CW'(pop);
         discard_d  = discard_q - OW'(rsp_ok && (discard_q != '0));
      end
   end

   // The storage array is cleared so that the head fields read zero out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= mem_d[i];
         end
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
      end
   end

   a_rsp_without_req : assert property (@(posedge clk) disable iff (!rst)
      imem_rsp_valid |-> (outstanding_q != '0));

   a_push_when_full : assert property (@(posedge clk) disable iff (!rst)
      push |-> (count_q != CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue.
// A memory model answers requests in order, and a scoreboard holds the words the queue should deliver.
// The expected values come from program order after each reset or redirect.
module tb_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam int          MAX_OUT  = 2;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc_plus4;

   fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc_plus4  (inst_pc_plus4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      bit          squashed;
   } req_t;

   int          errors = 0;
   int          checks = 0;
   req_t        pend_q[$];      // requests the memory has accepted, oldest first
   logic [63:0] exp_q[$];       // {pc_plus4, inst} words the FIFO should hold
   logic [31:0] model_pc = RESET_PC;

   // Stimulus knobs, given as percentages.
   int          p_req_ready  = 100;
   int          p_rsp        = 100;
   int          p_inst_ready = 100;
   int          p_redirect   = 0;
   bit          force_redirect = 1'b0;
   logic [31:0] force_pc = '0;

   int          live_n;
   bit          exp_rv, exp_iv;
   req_t        r;
   logic [63:0] e;
   bit          found;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   function automatic bit roll(input int pct);
      return int'($urandom_range(99)) < pct;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Driver: applies new inputs on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            redirect       = 1'b0;
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'b0;
            inst_ready     = 1'b0;
            force_redirect = 1'b0;
         end else begin
            redirect = force_redirect || roll(p_redirect);
            if (force_redirect) redirect_pc = force_pc;
            else if (roll(25)) redirect_pc = 32'hFFFFFFF0 + ($urandom & 32'hC);
            else redirect_pc = $urandom & 32'hFFFFFFFC;
            force_redirect = 1'b0;
            imem_req_ready = roll(p_req_ready);
            inst_ready     = roll(p_inst_ready);
            if (pend_q.size() > 0 && roll(p_rsp)) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = word_of(pend_q[0].addr);
            end else begin
               imem_rsp_valid = 1'b0;
               imem_rsp_data  = $urandom;
            end
         end
      end
   end

   // Monitor and scoreboard: compares the outputs that the next rising edge will act on,
   // then advances the reference model across that edge.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            chk("rst_inst_valid", 32'(inst_valid), 32'd0);
            chk("rst_req_addr", imem_req_addr, RESET_PC);
            chk("rst_inst", inst, 32'd0);
            chk("rst_pc_plus4", inst_pc_plus4, 32'd0);
            pend_q.delete();
            exp_q.delete();
            model_pc = RESET_PC;
         end else begin
            live_n = 0;
            foreach (pend_q[i]) if (!pend_q[i].squashed) live_n++;
            exp_rv = !redirect && (pend_q.size() < MAX_OUT) && (exp_q.size() + live_n < DEPTH);
            chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
            if (exp_rv && imem_req_valid) chk("req_addr", imem_req_addr, model_pc);
            exp_iv = !redirect && (exp_q.size() != 0);
            chk("inst_valid", 32'(inst_valid), 32'(exp_iv));
            if (exp_iv && inst_valid && inst_ready) begin
               e = exp_q.pop_front();
               chk("inst_pc_plus4", inst_pc_plus4, e[63:32]);
               chk("inst", inst, e[31:0]);
            end
            if (imem_rsp_valid && pend_q.size() > 0) begin
               r = pend_q.pop_front();
               if (!r.squashed && !redirect) exp_q.push_back({r.addr + 32'd4, word_of(r.addr)});
            end
            if (imem_req_valid && imem_req_ready) begin
               pend_q.push_back('{addr: model_pc, squashed: 1'b0});
               model_pc = model_pc + 32'd4;
            end
            if (redirect) begin
               foreach (pend_q[i]) pend_q[i].squashed = 1'b1;
               exp_q.delete();
               model_pc = redirect_pc;
            end
         end
      end
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog: simulation did not finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset, then streaming with every handshake always ready.
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (30) @(posedge clk);

      // Stall the consumer: the queue fills to DEPTH and fetch stops.
      p_inst_ready = 0;
      repeat (10) @(posedge clk);
      #1;
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      chk("stall_inst_valid", 32'(inst_valid), 32'd1);
      p_inst_ready = 100;
      repeat (20) @(posedge clk);

      // Two requests (0x10 and 0x14) in flight, then a redirect to 0x100.
      p_req_ready = 0;
      repeat (4) @(posedge clk);
      force_pc = 32'h10; force_redirect = 1'b1; p_rsp = 0; p_req_ready = 100;
      repeat (4) @(posedge clk);
      #1 chk("two_inflight_req_valid", 32'(imem_req_valid), 32'd0);
      force_pc = 32'h100; force_redirect = 1'b1; p_rsp = 100;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk); #3;
         if (inst_valid) begin
            found = 1'b1;
            chk("redirect_first_pc_plus4", inst_pc_plus4, 32'h104);
         end
      end
      chk("redirect_word_seen", 32'(found), 32'd1);
      repeat (10) @(posedge clk);

      // Redirect coinciding with a response and a pop.
      @(posedge clk);
      force_pc = 32'h200; force_redirect = 1'b1;
      @(negedge clk); #3;
      chk("redirect_cycle_inst_valid", 32'(inst_valid), 32'd0);
      @(negedge clk); #3;
      chk("after_redirect_empty", 32'(inst_valid), 32'd0);
      repeat (10) @(posedge clk);

      // Fetch PC wraps past 0xFFFFFFFC.
      force_pc = 32'hFFFFFFF8; force_redirect = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk); #3;
         if (inst_valid && inst_ready && inst_pc_plus4 == 32'h0) begin
            found = 1'b1;
            chk("wrap_inst", inst, word_of(32'hFFFFFFFC));
         end
      end
      chk("wrap_seen", 32'(found), 32'd1);

      // Reset in the middle of traffic, with the queue partly full and requests in flight.
      p_inst_ready = 0; p_rsp = 50;
      repeat (6) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midrst_inst_valid", 32'(inst_valid), 32'd0);
      chk("midrst_req_addr", imem_req_addr, RESET_PC);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      p_inst_ready = 100; p_rsp = 100;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk); #3;
         if (imem_req_valid) begin
            found = 1'b1;
            chk("post_reset_first_addr", imem_req_addr, RESET_PC);
         end
      end
      chk("post_reset_req_seen", 32'(found), 32'd1);

      // Random traffic with random redirects.
      p_redirect = 3;
      for (int k = 0; k < 30; k++) begin
         p_req_ready  = int'($urandom_range(30, 100));
         p_rsp        = int'($urandom_range(20, 100));
         p_inst_ready = int'($urandom_range(10, 100));
         repeat (50) @(posedge clk);
      end
      p_redirect = 0;
      repeat (5) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
